// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream input and memory write-port bundle for mem_loader.
interface mem_loader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic                  abort;
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  busy;
   logic                  done;
   modport slave (
      input  start, abort, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done
   );
   modport master (
      output start, abort, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
   );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: packs a little-endian byte stream into words written to sequential memory addresses.
module mem_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_WORDS  = 2**ADDR_WIDTH
) (
   input logic       clk,
   input logic       rst_n,
   mem_loader_if.slave bus
);
   localparam int BPW = DATA_WIDTH / 8;
   localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
   if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $error("mem_loader: DATA_WIDTH must be a non-zero multiple of 8");
   end
   if (NUM_WORDS < 1 || NUM_WORDS > 2**ADDR_WIDTH) begin : g_bad_words
      $error("mem_loader: NUM_WORDS out of range");
   end
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
   state_t                state, state_nx;
   logic [BW-1:0]         idx, idx_nx;
   logic [ADDR_WIDTH:0]   cnt, cnt_nx;
   logic [DATA_WIDTH-1:0] asm_q, asm_nx, word;
   logic                  we_nx, acc, last;
   assign acc          = bus.in_valid & bus.in_ready;
   assign last         = idx == BW'(BPW - 1);
   assign bus.in_ready = state == LOAD;
   assign bus.busy     = state == LOAD;
   assign bus.done     = state == DONE;
   always_comb begin
      word = asm_q;
      word[8*idx +: 8] = bus.in_data;
   end
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      asm_nx   = asm_q;
      we_nx    = 1'b0;
      unique case (state)
         LOAD: begin
            // abort outranks a byte accepted in the same cycle
            if (bus.abort) begin
               state_nx = IDLE;
               idx_nx   = '0;
            end else if (acc) begin
               asm_nx = word;
               idx_nx = last ? '0 : idx + BW'(1);
               if (last) begin
                  we_nx    = 1'b1;
                  cnt_nx   = cnt + (ADDR_WIDTH+1)'(1);
                  state_nx = cnt == (ADDR_WIDTH+1)'(NUM_WORDS - 1) ? DONE : LOAD;
               end
            end
         end
         IDLE, DONE: begin
            if (bus.start) begin
               state_nx = LOAD;
               idx_nx   = '0;
               cnt_nx   = '0;
               asm_nx   = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         cnt           <= '0;
         asm_q         <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         cnt        <= cnt_nx;
         asm_q      <= asm_nx;
         bus.mem_we <= we_nx;
         if (we_nx) begin
            bus.mem_addr  <= cnt[ADDR_WIDTH-1:0];
            bus.mem_wdata <= word;
         end
      end
   end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: drives two loader configurations with one shared byte stream and compares both
// against a word-level reference model every cycle.
module tb_mem_loader;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   int         n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
   // instance A: 16-bit words, 2 words; instance B: 8-bit words, 4 words, 2-bit address
   mem_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) ia ();
   mem_loader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8))  ib ();
   assign ia.start = start;
   assign ia.abort = abort;
   assign ia.in_valid = in_valid;
   assign ia.in_data = in_data;
   assign ib.start = start;
   assign ib.abort = abort;
   assign ib.in_valid = in_valid;
   assign ib.in_data = in_data;
   mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_WORDS(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
   mem_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(8),  .NUM_WORDS(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
   int         bpw [2] = '{2, 1};
   int         nw  [2] = '{2, 4};
   logic       m_load [2], m_done [2], m_we [2];
   logic [7:0] m_addr [2];
   logic [15:0] m_wdata [2];
   int         m_cnt [2], m_n [2];
   logic [7:0] m_b [2][2];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_load[i] = 1'b0;
         m_done[i] = 1'b0;
         m_we[i] = 1'b0;
         m_addr[i] = 8'h00;
         m_wdata[i] = 16'h0000;
         m_cnt[i] = 0;
         m_n[i] = 0;
      end
   endtask
   task automatic model_step();
      logic [15:0] w;
      for (int i = 0; i < 2; i++) begin
         m_we[i] = 1'b0;
         if (!m_load[i]) begin
            if (start) begin
               m_load[i] = 1'b1;
               m_done[i] = 1'b0;
               m_cnt[i] = 0;
               m_n[i] = 0;
            end
         end else if (abort) begin
            m_load[i] = 1'b0;
            m_n[i] = 0;
         end else if (in_valid) begin
            m_b[i][m_n[i]] = in_data;
            m_n[i]++;
            if (m_n[i] == bpw[i]) begin
               w = 16'h0000;
               for (int k = 0; k < bpw[i]; k++) w |= 16'(m_b[i][k]) << (8 * k);
               m_we[i] = 1'b1;
               m_addr[i] = 8'(m_cnt[i]);
               m_wdata[i] = w;
               m_cnt[i]++;
               m_n[i] = 0;
               if (m_cnt[i] == nw[i]) begin
                  m_load[i] = 1'b0;
                  m_done[i] = 1'b1;
               end
            end
         end
      end
   endtask
   task automatic check_all();
      check("A.ctl", {28'd0, ia.in_ready, ia.busy, ia.done, ia.mem_we}, {28'd0, m_load[0], m_load[0], m_done[0], m_we[0]});
      check("A.addr", 32'(ia.mem_addr), 32'(m_addr[0]));
      check("A.data", 32'(ia.mem_wdata), 32'(m_wdata[0]));
      check("B.ctl", {28'd0, ib.in_ready, ib.busy, ib.done, ib.mem_we}, {28'd0, m_load[1], m_load[1], m_done[1], m_we[1]});
      check("B.addr", 32'(ib.mem_addr), 32'(m_addr[1][1:0]));
      check("B.data", 32'(ib.mem_wdata), 32'(m_wdata[1][7:0]));
   endtask
   task automatic step(input logic s, input logic a, input logic v, input logic [7:0] d);
      start = s;
      abort = a;
      in_valid = v;
      in_data = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask
   task automatic async_rst();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      check("rst.we", {30'd0, ia.mem_we, ib.mem_we}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
   endtask
   initial begin
      #2 model_reset();
      check_all();
      @(negedge clk) rst_n = 1'b1;
      step(0, 0, 0, 8'h00);
      // two 16-bit words back to back
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h34);
      step(0, 0, 1, 8'h12);
      check("t1.w0", 32'({ia.mem_we, ia.mem_addr, ia.mem_wdata}), 32'({1'b1, 8'h00, 16'h1234}));
      step(0, 0, 1, 8'h78);
      step(0, 0, 1, 8'h56);
      check("t1.w1", 32'({ia.mem_we, ia.in_ready, ia.mem_addr, ia.mem_wdata}), 32'({2'b10, 8'h01, 16'h5678}));
      step(0, 0, 0, 8'h00);
      check("t1.done", 32'({ia.done, ia.mem_we}), 32'd2);
      // byte-wide words with in_valid held high
      step(1, 0, 0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 1, 8'(8'hAA + k));
         check("t2.w", 32'({ib.mem_we, ib.mem_addr, ib.mem_wdata}), 32'({1'b1, 2'(k), 8'(8'hAA + k)}));
      end
      step(0, 0, 1, 8'hEE);
      check("t5.rdy", 32'({ib.in_ready, ib.done}), 32'd1);
      // throttled source
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h34);
      step(0, 0, 0, 8'h99);
      step(0, 0, 1, 8'h12);
      step(0, 0, 0, 8'h99);
      step(0, 0, 1, 8'h78);
      step(0, 0, 0, 8'h99);
      step(0, 0, 1, 8'h56);
      // abort after one byte of word 1, then restart from address 0
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h34);
      step(0, 0, 1, 8'h12);
      step(0, 0, 1, 8'h78);
      step(0, 1, 1, 8'h56);
      check("t4.idle", 32'({ia.busy, ia.done, ia.mem_we}), 32'd0);
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h9A);
      step(0, 0, 1, 8'hBC);
      check("t4.re", 32'({ia.mem_we, ia.mem_addr, ia.mem_wdata}), 32'({1'b1, 8'h00, 16'hBC9A}));
      // reset mid-word, then during a write pulse
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h34);
      async_rst();
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h11);
      step(0, 0, 1, 8'h22);
      check("t6.we", 32'({ia.mem_we, ia.mem_addr, ia.mem_wdata}), 32'({1'b1, 8'h00, 16'h2211}));
      async_rst();
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h44);
      step(0, 0, 1, 8'h33);
      check("t6.re", 32'({ia.mem_we, ia.mem_addr, ia.mem_wdata}), 32'({1'b1, 8'h00, 16'h3344}));
      // random traffic with occasional start, abort and reset
      for (int n = 0; n < 600; n++) begin
         step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 2) != 0), 8'($urandom));
         if ($urandom_range(0, 59) == 0) async_rst();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
